// File: rtl/gate_seq_ctrl.sv
// gate_seq_ctrl: steps a gate program through one gsm instance.
// Holds the working state vector, walks the gate memory address, waits for the
// gsm datapath to settle, then captures the gsm result as the new state.
//
// Control protocol (pulse based, no back-pressure):
//   start is a request strobe that is accepted only while idle; the block has no
//   ready output because it is idle exactly when busy==0 and done==0. done is a
//   single-cycle completion strobe. abort is a strobe honoured only while busy.
module gate_seq_ctrl #(
    parameter  int N         = 2,
    parameter  int MAX_GATES = 16,
    parameter  int MULT_LAT  = 1,
    localparam int NE        = 1 << N,
    localparam int SW        = 16 * NE,
    localparam int CW        = $clog2(MAX_GATES + 1),
    localparam int AW        = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] num_gates,
    input  logic [SW-1:0] init_state,
    output logic [AW-1:0] gate_addr,
    output logic [SW-1:0] gsm_state,
    input  logic [SW-1:0] gsm_result,
    output logic          busy,
    output logic          done,
    output logic [1:0]    fsm_state
);

    localparam int WW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_r, state_nx;
    logic [SW-1:0] vec_r, vec_nx;
    logic [AW-1:0] addr_r, addr_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic [CW-1:0] count_r, count_nx;
    logic [WW-1:0] wcnt_r, wcnt_nx;
    logic [CW-1:0] clamped;

    // Programs longer than the gate memory are truncated to its depth.
    assign clamped = (num_gates > CW'(MAX_GATES)) ? CW'(MAX_GATES) : num_gates;

    // Register FSM state and the datapath registers it controls.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_IDLE;
            vec_r   <= '0;
            addr_r  <= '0;
            cnt_r   <= '0;
            count_r <= '0;
            wcnt_r  <= '0;
        end else begin
            state_r <= state_nx;
            vec_r   <= vec_nx;
            addr_r  <= addr_nx;
            cnt_r   <= cnt_nx;
            count_r <= count_nx;
            wcnt_r  <= wcnt_nx;
        end
    end

    // Next-state and datapath updates; abort wins over the WAIT capture.
    always_comb begin
        state_nx = state_r;
        vec_nx   = vec_r;
        addr_nx  = addr_r;
        cnt_nx   = cnt_r;
        count_nx = count_r;
        wcnt_nx  = wcnt_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    count_nx = clamped;
                    vec_nx   = init_state;
                    addr_nx  = '0;
                    cnt_nx   = '0;
                    state_nx = (clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else begin
                    wcnt_nx  = WW'(MULT_LAT - 1);
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_nx = S_IDLE;
                end else if (wcnt_r == '0) begin
                    vec_nx = gsm_result;
                    if ((cnt_r + 1'b1) == count_r) begin
                        state_nx = S_DONE;
                    end else begin
                        cnt_nx   = cnt_r + 1'b1;
                        addr_nx  = addr_r + 1'b1;
                        state_nx = S_FETCH;
                    end
                end else begin
                    wcnt_nx = wcnt_r - 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign gate_addr = addr_r;
    assign gsm_state = vec_r;
    assign busy      = (state_r == S_FETCH) || (state_r == S_WAIT);
    assign done      = (state_r == S_DONE);
    assign fsm_state = state_r;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// tb_gate_seq_ctrl: gate memory + gsm environment around gate_seq_ctrl with a
// cycle-level reference built from the program timing rules.
module tb_gate_seq_ctrl;

    localparam int N   = 2;
    localparam int NE  = 1 << N;
    localparam int SW  = 16 * NE;
    localparam int GW  = 16 * NE * NE;
    localparam int MG  = 16;
    localparam int L   = 1;
    localparam int P   = 1 + L;
    localparam int CW  = $clog2(MG + 1);
    localparam int AW  = $clog2(MG);
    localparam logic [15:0] ONE = 16'h4000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [CW-1:0] num_gates;
    logic [SW-1:0] init_state;
    logic [AW-1:0] gate_addr;
    logic [SW-1:0] gsm_state;
    logic [SW-1:0] gsm_result;
    logic          busy;
    logic          done;
    logic [1:0]    fsm_state;

    logic [GW-1:0] gmem [MG];
    logic [GW-1:0] gate_data;
    logic [SW-1:0] model_state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // clock
    always #5 clk = ~clk;

    gate_seq_ctrl #(.N(N), .MAX_GATES(MG), .MULT_LAT(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .num_gates  (num_gates),
        .init_state (init_state),
        .gate_addr  (gate_addr),
        .gsm_state  (gsm_state),
        .gsm_result (gsm_result),
        .busy       (busy),
        .done       (done),
        .fsm_state  (fsm_state)
    );

    // Real-only matrix times state vector in Q2.14.
    function automatic logic [SW-1:0] apply_gate(input logic [GW-1:0] m, input logic [SW-1:0] s);
        logic [SW-1:0] r;
        longint acc;
        r = '0;
        for (int i = 0; i < NE; i++) begin
            acc = 0;
            for (int j = 0; j < NE; j++)
                acc += longint'($signed(m[(i*NE+j)*16 +: 16])) * longint'($signed(s[j*16 +: 16]));
            r[i*16 +: 16] = 16'(acc >>> 14);
        end
        return r;
    endfunction

    // Gate memory with one cycle read latency, gsm as combinational product.
    always_ff @(posedge clk) gate_data <= gmem[gate_addr];
    always_comb gsm_result = apply_gate(gate_data, gsm_state);

    function automatic logic [GW-1:0] x_gate();
        logic [GW-1:0] m;
        m = '0;
        m[(0*NE+1)*16 +: 16] = ONE;
        m[(1*NE+0)*16 +: 16] = ONE;
        m[(2*NE+3)*16 +: 16] = ONE;
        m[(3*NE+2)*16 +: 16] = ONE;
        return m;
    endfunction

    function automatic logic [GW-1:0] rand_gate();
        logic [GW-1:0] m;
        int perm [NE];
        int j, t;
        m = '0;
        if ($urandom_range(0, 1) == 0) begin
            for (int i = 0; i < NE; i++) perm[i] = i;
            for (int i = NE - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < NE; i++)
                m[(i*NE+perm[i])*16 +: 16] = ($urandom_range(0, 1) == 0) ? ONE : 16'hC000;
        end else begin
            for (int i = 0; i < NE*NE; i++)
                m[i*16 +: 16] = 16'($urandom_range(0, 65535));
        end
        return m;
    endfunction

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] s;
        for (int i = 0; i < NE; i++) s[i*16 +: 16] = 16'($urandom_range(0, 65535));
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one program and checks every cycle against the timing rules:
    // gate i occupies cycles i*P+1 .. (i+1)*P, its result is visible from
    // cycle (i+1)*P+1, and done appears in cycle G*P+1.
    task automatic run_prog(input string name, input logic [SW-1:0] init, input int ng,
                            input int abort_at, input int restart_at);
        int g, lastc, ncap, k, done_c;
        bit aborted, busy_e, done_e;
        logic [SW-1:0] st [MG+1];
        g = (ng > MG) ? MG : ng;
        st[0] = init;
        for (int i = 0; i < g; i++) st[i+1] = apply_gate(gmem[i], st[i]);
        aborted = (abort_at >= 1) && (abort_at <= g * P);
        done_c  = g * P + 1;
        lastc   = aborted ? abort_at + 1 : done_c + 1;
        ncap    = aborted ? (abort_at - 1) / P : g;
        init_state = init;
        num_gates  = CW'(ng);
        start      = 1'b1;
        step();
        for (int c = 1; c <= lastc; c++) begin
            start      = (c == restart_at);
            abort      = (c == abort_at);
            num_gates  = CW'($urandom_range(0, 31));
            init_state = rand_state();
            k = (c - 1) / P;
            if (k > ncap) k = ncap;
            busy_e = aborted ? (c <= abort_at) : (c <= g * P);
            done_e = !aborted && (c == done_c);
            check($sformatf("%s busy c%0d", name, c), SW'(busy), SW'(busy_e));
            check($sformatf("%s done c%0d", name, c), SW'(done), SW'(done_e));
            check($sformatf("%s state c%0d", name, c), gsm_state, st[k]);
            if (busy_e)
                check($sformatf("%s addr c%0d", name, c), SW'(gate_addr), SW'((c - 1) / P));
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        model_state = st[ncap];
    endtask

    initial begin
        int ng, g, abort_at, restart_at, lim;
        logic [SW-1:0] s0;
        reset = 1'b0; start = 1'b0; abort = 1'b0; num_gates = '0; init_state = '0;
        for (int i = 0; i < MG; i++) gmem[i] = '0;
        repeat (2) step();
        check("reset busy", SW'(busy), '0);
        check("reset done", SW'(done), '0);
        check("reset state", gsm_state, '0);
        check("reset addr", SW'(gate_addr), '0);
        reset = 1'b1;
        step();

        // reset held low for 3 cycles in the middle of a program
        for (int i = 0; i < MG; i++) gmem[i] = rand_gate();
        init_state = rand_state();
        num_gates  = CW'(3);
        start      = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre-reset busy", SW'(busy), SW'(1));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            step();
            check($sformatf("midreset busy %0d", i), SW'(busy), '0);
            check($sformatf("midreset state %0d", i), gsm_state, '0);
        end
        reset = 1'b1;
        step();
        check("postreset busy", SW'(busy), '0);
        check("postreset done", SW'(done), '0);
        check("postreset state", gsm_state, '0);
        check("postreset addr", SW'(gate_addr), '0);

        // single X gate swaps elements 0 and 1
        gmem[0] = x_gate();
        s0 = '0;
        s0[15:0] = ONE;
        run_prog("x1", s0, 1, 0, 0);
        check("x1 final", gsm_state, {16'h0, 16'h0, ONE, 16'h0});

        // two X gates restore the initial vector
        gmem[1] = x_gate();
        run_prog("xx", s0, 2, 0, 0);
        check("xx final", gsm_state, s0);

        // empty program
        s0 = rand_state();
        run_prog("zero", s0, 0, 0, 0);
        check("zero final", gsm_state, s0);

        // abort in the second gate, in FETCH and in WAIT
        for (int i = 0; i < MG; i++) gmem[i] = rand_gate();
        run_prog("abortw", rand_state(), 3, 4, 0);
        run_prog("abortf", rand_state(), 3, 3, 0);

        // abort while idle is harmless
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle abort busy", SW'(busy), '0);
        check("idle abort state", gsm_state, model_state);

        // oversize program with a stray start mid-run
        run_prog("clamp", rand_state(), 20, 0, 2);
        check("clamp final", gsm_state, model_state);

        // start coincident with done is ignored; abort in DONE is ignored
        run_prog("donestart", rand_state(), 2, 0, 2 * P + 1);
        run_prog("doneabort", rand_state(), 2, 2 * P + 1, 0);

        // randomized programs
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < MG; i++) gmem[i] = rand_gate();
            ng = $urandom_range(0, 20);
            g  = (ng > MG) ? MG : ng;
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, g * P + 1) : 0;
            lim = (abort_at != 0 && abort_at <= g * P) ? abort_at : g * P + 1;
            restart_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, lim) : 0;
            run_prog($sformatf("rnd%0d", r), rand_state(), ng, abort_at, restart_at);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
